// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned multiply/divide unit owning the HI/LO pair
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               dz;

  logic               op_md;
  logic               op_signed;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op_md     = ~op[2];
  assign op_signed = ~op[0];
  assign a_abs     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (op_signed && b[WIDTH-1]) ? -b : b;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};

  always_comb begin
    acc_step = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_diff[WIDTH])
        acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !cancel) begin
            if (op_md) begin
              acc     <= {{WIDTH{1'b0}}, a_abs};
              opb     <= b_abs;
              is_div  <= op[1];
              neg_res <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem <= op_signed && a[WIDTH-1];
              dz      <= op[1] && (b == '0);
              cnt     <= CNT_W'(WIDTH);
              busy    <= 1'b1;
              state   <= S_CALC;
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        S_CALC: begin
          if (cancel) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_step;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
              state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            done <= 1'b1;
            if (dz) begin
              div_zero <= 1'b1;
            end else if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;

  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a[7:0]), .b(b[7:0]), .cancel(cancel),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer multiply/divide on sign- or zero-extended operands
  function automatic void md_ref(input int w, input logic [2:0] o, input logic [63:0] av,
                                 input logic [63:0] bv, output logic [63:0] h,
                                 output logic [63:0] l, output logic z);
    logic [63:0] mask;
    logic [63:0] ua, ub, t;
    longint sa, sb;
    logic signed [127:0] pa, pb, sp;
    logic [127:0] up;
    mask = (64'd1 << w) - 64'd1;
    ua = av & mask;
    ub = bv & mask;
    sa = longint'(ua << (64 - w)) >>> (64 - w);
    sb = longint'(ub << (64 - w)) >>> (64 - w);
    h = 64'd0; l = 64'd0; z = 1'b0;
    case (o)
      3'd0: begin
        pa = sa; pb = sb; sp = pa * pb;
        h = 64'(sp >> w) & mask;
        l = 64'(sp) & mask;
      end
      3'd1: begin
        up = {64'd0, ua} * {64'd0, ub};
        h = 64'(up >> w) & mask;
        l = 64'(up) & mask;
      end
      3'd2: begin
        if (ub == 64'd0) z = 1'b1;
        else begin
          t = sa / sb; l = t & mask;
          t = sa % sb; h = t & mask;
        end
      end
      default: begin
        if (ub == 64'd0) z = 1'b1;
        else begin
          l = (ua / ub) & mask;
          h = (ua % ub) & mask;
        end
      end
    endcase
  endfunction

  // Model: index 0 is the 32-bit unit, index 1 the 8-bit unit
  int          m_w[2]    = '{32, 8};
  int          m_cnt[2]  = '{0, 0};
  logic        m_busy[2] = '{1'b0, 1'b0};
  logic        m_done[2] = '{1'b0, 1'b0};
  logic        m_dz[2]   = '{1'b0, 1'b0};
  logic [63:0] m_hi[2]   = '{64'd0, 64'd0};
  logic [63:0] m_lo[2]   = '{64'd0, 64'd0};
  logic [63:0] p_hi[2]   = '{64'd0, 64'd0};
  logic [63:0] p_lo[2]   = '{64'd0, 64'd0};
  logic        p_dz[2]   = '{1'b0, 1'b0};

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_cnt[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_dz[i] = 1'b0;
        m_hi[i] = 64'd0; m_lo[i] = 64'd0;
      end else begin
        m_done[i] = 1'b0;
        m_dz[i]   = 1'b0;
        if (m_busy[i]) begin
          if (cancel) m_busy[i] = 1'b0;
          else begin
            m_cnt[i]--;
            if (m_cnt[i] == 0) begin
              m_busy[i] = 1'b0;
              m_done[i] = 1'b1;
              if (p_dz[i]) m_dz[i] = 1'b1;
              else begin
                m_hi[i] = p_hi[i];
                m_lo[i] = p_lo[i];
              end
            end
          end
        end else if (start && !cancel) begin
          if (op <= 3'd3) begin
            md_ref(m_w[i], op, {32'd0, a}, {32'd0, b}, p_hi[i], p_lo[i], p_dz[i]);
            m_busy[i] = 1'b1;
            m_cnt[i]  = m_w[i] + 1;
          end else if (op == 3'd4) begin
            m_hi[i] = {32'd0, a} & ((64'd1 << m_w[i]) - 64'd1);
          end else if (op == 3'd5) begin
            m_lo[i] = {32'd0, a} & ((64'd1 << m_w[i]) - 64'd1);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy32", 64'(busy32), 64'(m_busy[0]));
    chk("done32", 64'(done32), 64'(m_done[0]));
    chk("div_zero32", 64'(dz32), 64'(m_dz[0]));
    chk("hi32", 64'(hi32), m_hi[0]);
    chk("lo32", 64'(lo32), m_lo[0]);
    chk("busy8", 64'(busy8), 64'(m_busy[1]));
    chk("done8", 64'(done8), 64'(m_done[1]));
    chk("div_zero8", 64'(dz8), 64'(m_dz[1]));
    chk("hi8", 64'(hi8), m_hi[1]);
    chk("lo8", 64'(lo8), m_lo[1]);
  end

  int   lat32, lat8, bcnt32, bcnt8;
  logic dzs32;

  // Issues one op, then watches up to 40 edges; E0 is the first edge of the loop (k=0)
  task automatic run(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                     input int mid_k, input int cancel_k);
    lat32 = 0; lat8 = 0; bcnt32 = 0; bcnt8 = 0; dzs32 = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = av; b = bv;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 0) start = 1'b0;
      if (k == mid_k) begin start = 1'b1; op = 3'd1; a = 32'd1; b = 32'd1; end
      if (k == mid_k + 1) start = 1'b0;
      if (k == cancel_k) cancel = 1'b1;
      if (k == cancel_k + 1) cancel = 1'b0;
      if (busy32) bcnt32++;
      if (busy8) bcnt8++;
      if (done32 && lat32 == 0) begin lat32 = k; dzs32 = dz32; end
      if (done8 && lat8 == 0) lat8 = k;
    end
    start = 1'b0; cancel = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0080;
      4: return 32'($urandom_range(0, 3));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy32), 64'd0);
    chk("reset_hi", 64'(hi32), 64'd0);
    chk("reset_lo", 64'(lo32), 64'd0);
    reset = 1'b0;

    run(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, -10, -10);
    chk("mult_lat32", 64'(lat32), 64'd33);
    chk("mult_busy32", 64'(bcnt32), 64'd33);
    chk("mult_hi32", 64'(hi32), 64'hFFFF_FFFF);
    chk("mult_lo32", 64'(lo32), 64'hFFFF_FFFA);
    chk("mult_lat8", 64'(lat8), 64'd9);
    chk("mult_busy8", 64'(bcnt8), 64'd9);
    chk("mult_hi8", 64'(hi8), 64'hFF);
    chk("mult_lo8", 64'(lo8), 64'hFA);

    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, -10);
    chk("multu_hi32", 64'(hi32), 64'hFFFF_FFFE);
    chk("multu_lo32", 64'(lo32), 64'h0000_0001);
    chk("multu_hi8", 64'(hi8), 64'hFE);
    chk("multu_lo8", 64'(lo8), 64'h01);

    run(3'd2, 32'hFFFF_FFF9, 32'd2, -10, -10);
    chk("div_lo32", 64'(lo32), 64'hFFFF_FFFD);
    chk("div_hi32", 64'(hi32), 64'hFFFF_FFFF);
    chk("div_lat8", 64'(lat8), 64'd9);
    chk("div_lo8", 64'(lo8), 64'hFD);
    chk("div_hi8", 64'(hi8), 64'hFF);

    run(3'd3, 32'hFFFF_FFF9, 32'd2, -10, -10);
    chk("divu_lo32", 64'(lo32), 64'h7FFF_FFFC);
    chk("divu_hi32", 64'(hi32), 64'h0000_0001);
    chk("divu_lo8", 64'(lo8), 64'h7C);

    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; a = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mthi_busy32", 64'(busy32), 64'd0);
    run(3'd3, 32'd5, 32'd0, -10, -10);
    chk("dz_lat32", 64'(lat32), 64'd33);
    chk("dz_flag32", 64'(dzs32), 64'd1);
    chk("dz_hi32", 64'(hi32), 64'h1234);
    chk("dz_hi8", 64'(hi8), 64'h34);

    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -10, -10);
    chk("ovf_lo32", 64'(lo32), 64'h8000_0000);
    chk("ovf_hi32", 64'(hi32), 64'h0);
    chk("ovf_dz32", 64'(dzs32), 64'd0);

    run(3'd1, 32'd3, 32'd4, -10, 10);
    chk("cancel_nodone32", 64'(lat32), 64'd0);
    chk("cancel_hi32", 64'(hi32), 64'h0);
    chk("cancel_lo32", 64'(lo32), 64'h8000_0000);
    chk("cancel_busy32", 64'(bcnt32), 64'd11);
    chk("cancel_lo8", 64'(lo8), 64'h0C);

    @(posedge clk); #1;
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_hi32", 64'(hi32), 64'd0);
    chk("rst_lo32", 64'(lo32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_dz32", 64'(dz32), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_hi8", 64'(hi8), 64'd0);
    chk("rst_lo8", 64'(lo8), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start  = ($urandom_range(0, 2) == 0);
      op     = 3'($urandom_range(0, 7));
      a      = pick();
      b      = pick();
      cancel = ($urandom_range(0, 39) == 0);
    end
    start = 1'b0; cancel = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
